// File: rtl/alu_seq.sv
// alu_seq: handshaked 16-function ALU with iterated shifts. Latency is 1 cycle, or n+1 for an n-bit shift.
// Backpressure: the result is held in DONE until out_ready, and no request is accepted there.
module alu_seq #(
  parameter  int DATA_WIDTH = 16,
  localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            func_code,
  input  logic                  var_shift,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] C,
  output logic                  overflow_flag,
  output logic                  zero_flag,
  output logic                  neg_flag
);

  localparam logic [3:0] FUNC_ADD  = 4'd0,  FUNC_SUB  = 4'd1,  FUNC_ID   = 4'd2,  FUNC_NOT  = 4'd3;
  localparam logic [3:0] FUNC_AND  = 4'd4,  FUNC_OR   = 4'd5,  FUNC_NAND = 4'd6,  FUNC_NOR  = 4'd7;
  localparam logic [3:0] FUNC_XOR  = 4'd8,  FUNC_XNOR = 4'd9,  FUNC_LLS  = 4'd10, FUNC_LRS  = 4'd11;
  localparam logic [3:0] FUNC_ALS  = 4'd12, FUNC_ARS  = 4'd13, FUNC_TCP  = 4'd14, FUNC_ZERO = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]              sop_q, sop_d;
  logic [DATA_WIDTH-1:0]   c_q, c_d;
  logic                    of_q, of_d, z_q, z_d, n_q, n_d;

  logic [DATA_WIDTH-1:0]   sum, diff, alu_res, step, load_val;
  logic                    alu_of, is_shift, load_en, load_of;
  logic [SHAMT_W-1:0]      shamt_req;

  assign sum       = A + B;
  assign diff      = A - B;
  assign is_shift  = (func_code == FUNC_LLS) || (func_code == FUNC_LRS) ||
                     (func_code == FUNC_ALS) || (func_code == FUNC_ARS);
  assign shamt_req = var_shift ? B[SHAMT_W-1:0] : SHAMT_W'(1);

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    unique case (func_code)
      FUNC_ADD: begin
        alu_res = sum;
        alu_of  = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
      end
      FUNC_SUB: begin
        alu_res = diff;
        alu_of  = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) && (diff[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
      end
      FUNC_ID:   alu_res = A;
      FUNC_NOT:  alu_res = ~A;
      FUNC_AND:  alu_res = A & B;
      FUNC_OR:   alu_res = A | B;
      FUNC_NAND: alu_res = ~(A & B);
      FUNC_NOR:  alu_res = ~(A | B);
      FUNC_XOR:  alu_res = A ^ B;
      FUNC_XNOR: alu_res = ~(A ^ B);
      FUNC_TCP:  alu_res = (~A) + DATA_WIDTH'(1);
      FUNC_ZERO: alu_res = '0;
      FUNC_LLS, FUNC_LRS, FUNC_ALS, FUNC_ARS: alu_res = A;
    endcase
  end

  // One-bit step of the shift captured at acceptance.
  always_comb begin
    step = work_q;
    case (sop_q)
      FUNC_LLS, FUNC_ALS: step = {work_q[DATA_WIDTH-2:0], 1'b0};
      FUNC_LRS:           step = {1'b0, work_q[DATA_WIDTH-1:1]};
      FUNC_ARS:           step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
      default:            step = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = (is_shift && shamt_req != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    work_d   = work_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    load_en  = 1'b0;
    load_val = '0;
    load_of  = 1'b0;
    if (state_q == S_IDLE && in_valid) begin
      if (is_shift && shamt_req != '0) begin
        work_d = A;
        cnt_d  = shamt_req;
        sop_d  = func_code;
      end else begin
        load_en  = 1'b1;
        load_val = alu_res;
        load_of  = alu_of;
      end
    end else if (state_q == S_SHIFT) begin
      work_d = step;
      cnt_d  = cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) begin
        load_en  = 1'b1;
        load_val = step;
      end
    end
    c_d  = load_en ? load_val : c_q;
    of_d = load_en ? load_of : of_q;
    z_d  = load_en ? (load_val == '0) : z_q;
    n_d  = load_en ? load_val[DATA_WIDTH-1] : n_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      sop_q   <= '0;
      c_q     <= '0;
      of_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      c_q     <= c_d;
      of_q    <= of_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    in_ready      = (state_q == S_IDLE);
    out_valid     = (state_q == S_DONE);
    C             = c_q;
    overflow_flag = of_q;
    zero_flag     = z_q;
    neg_flag      = n_q;
  end

endmodule
